// File: rtl/traffic_pkg.sv
// Shared definitions between the traffic generator and the packet receiver.
// Holds the packet encoding, default LFSR constants and the LFSR step equation.
package traffic_pkg;

   localparam logic PKT_UL = 1'b0;
   localparam logic PKT_DL = 1'b1;

   localparam logic [7:0] UL_SEED_DEF = 8'hAA;
   localparam logic [7:0] UL_TAPS_DEF = 8'hB4;
   localparam logic [7:0] DL_SEED_DEF = 8'h55;
   localparam logic [7:0] DL_TAPS_DEF = 8'hD8;

   typedef struct packed {
      logic       pkt_type;
      logic [7:0] id;
   } pkt_t;

   // Galois-free left shift with the XOR of the tapped bits fed into bit 0.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur, input logic [7:0] taps);
      return {cur[6:0], ^(cur & taps)};
   endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Small synchronous FIFO with a separate occupancy counter.
// The caller is responsible for never pushing into a full FIFO without a pop.
module pkt_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

   // Storage needs no reset; stale entries are masked by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/pkt_rx_checker.sv
// Receives the generator's packet stream, buffers it, counts traffic and
// checks each ID against locally regenerated UL/DL LFSR sequences.
module pkt_rx_checker
   import traffic_pkg::*;
#(
   parameter int         DEPTH   = 4,
   parameter logic [7:0] UL_SEED = UL_SEED_DEF,
   parameter logic [7:0] UL_TAPS = UL_TAPS_DEF,
   parameter logic [7:0] DL_SEED = DL_SEED_DEF,
   parameter logic [7:0] DL_TAPS = DL_TAPS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_id,
   input  logic       in_type,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_id,
   output logic       out_type,
   output logic [7:0] ul_count,
   output logic [7:0] dl_count,
   output logic [7:0] drop_count,
   output logic [7:0] err_count,
   output logic       err_seen
);

   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic                    drop;
   logic                    mismatch;
   logic [7:0]              ul_exp;
   logic [7:0]              dl_exp;
   logic [7:0]              sel_exp;
   pkt_t                    in_pkt;
   pkt_t                    head_pkt;
   logic [$bits(pkt_t)-1:0] head_bits;

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && (!full || pop);
   assign drop      = in_valid && !push;
   assign in_pkt    = '{pkt_type: in_type, id: in_id};

   pkt_fifo #(
      .WIDTH ($bits(pkt_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (in_pkt),
      .full      (full),
      .empty     (empty),
      .head      (head_bits)
   );

   assign head_pkt = pkt_t'(head_bits);
   assign out_id   = out_valid ? head_pkt.id : 8'h00;
   assign out_type = out_valid ? head_pkt.pkt_type : 1'b0;

   assign sel_exp  = (in_type == PKT_DL) ? dl_exp : ul_exp;
   assign mismatch = in_valid && (in_id != sel_exp);

   // Only the register of the arriving type advances, whether or not it matched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ul_exp <= UL_SEED;
         dl_exp <= DL_SEED;
      end else if (in_valid) begin
         if (in_type == PKT_DL)
            dl_exp <= lfsr_next(dl_exp, DL_TAPS);
         else
            ul_exp <= lfsr_next(ul_exp, UL_TAPS);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ul_count   <= '0;
         dl_count   <= '0;
         drop_count <= '0;
         err_count  <= '0;
         err_seen   <= 1'b0;
      end else begin
         if (in_valid && in_type == PKT_UL) ul_count <= ul_count + 8'd1;
         if (in_valid && in_type == PKT_DL) dl_count <= dl_count + 8'd1;
         if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
         if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (mismatch) err_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Randomized self-checking bench for pkt_rx_checker against a queue-based
// behavioural model of the receive path, counters and sequence checker.
module tb_pkt_rx_checker;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_id = 8'h00;
   logic       in_type = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_id;
   logic       out_type;
   logic [7:0] ul_count;
   logic [7:0] dl_count;
   logic [7:0] drop_count;
   logic [7:0] err_count;
   logic       err_seen;
   logic [42:0] dut_vec;

   int vectors = 0;
   int miscompares = 0;

   logic [8:0] q[$];
   logic [7:0] m_ul, m_dl, m_ul_exp, m_dl_exp;
   int         m_drop, m_err;
   logic       m_seen;

   pkt_rx_checker #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_id      (in_id),
      .in_type    (in_type),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_id     (out_id),
      .out_type   (out_type),
      .ul_count   (ul_count),
      .dl_count   (dl_count),
      .drop_count (drop_count),
      .err_count  (err_count),
      .err_seen   (err_seen)
   );

   always #5 clk = ~clk;

   assign dut_vec = {out_valid, out_id, out_type, ul_count, dl_count, drop_count, err_count, err_seen};

   // Reference sequence step: shift left, feed in the parity of the tapped bits.
   function automatic logic [7:0] ref_lfsr(input logic [7:0] cur, input logic [7:0] taps);
      logic fb;
      fb = ($countones(cur & taps) % 2) == 1;
      return {cur[6:0], fb};
   endfunction

   function automatic logic [42:0] exp_vec();
      logic [8:0] h;
      logic       v;
      v = q.size() > 0;
      h = v ? q[0] : 9'd0;
      return {v, h[7:0], h[8], m_ul, m_dl, m_drop[7:0], m_err[7:0], m_seen};
   endfunction

   task automatic model_reset();
      q.delete();
      m_ul = 0; m_dl = 0; m_drop = 0; m_err = 0; m_seen = 0;
      m_ul_exp = 8'hAA;
      m_dl_exp = 8'h55;
   endtask

   // Drives one cycle of stimulus and advances the model by the same cycle.
   task automatic step(input logic v, input logic [7:0] id, input logic t, input logic rdy);
      logic pop_now, acc;
      logic [7:0] expect_id;
      in_valid  = v;
      in_id     = id;
      in_type   = t;
      out_ready = rdy;
      pop_now = (q.size() > 0) && rdy;
      acc     = v && ((q.size() < DEPTH) || pop_now);
      if (pop_now) void'(q.pop_front());
      if (acc) q.push_back({t, id});
      if (v) begin
         if (t) m_dl = m_dl + 8'd1; else m_ul = m_ul + 8'd1;
         if (!acc && m_drop < 255) m_drop++;
         expect_id = t ? m_dl_exp : m_ul_exp;
         if (id != expect_id) begin
            if (m_err < 255) m_err++;
            m_seen = 1'b1;
         end
         if (t) m_dl_exp = ref_lfsr(m_dl_exp, 8'hD8);
         else   m_ul_exp = ref_lfsr(m_ul_exp, 8'hB4);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      out_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #2;
      vectors++;
      if (dut_vec !== 43'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", dut_vec, 43'd0);
      end
      do_reset();
   endtask

   task automatic test_basic_stream();
      logic [7:0] ids [4] = '{8'hAA, 8'h55, 8'h54, 8'hAA};
      logic       tys [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, ids[i], tys[i], 1'b1);
         vectors++;
         if ({out_valid, out_id, out_type} !== {1'b1, ids[i], tys[i]}) begin
            miscompares++;
            $display("[TB] FAIL basic_head%0d: got %b/%h/%b expected 1/%h/%b",
                     i, out_valid, out_id, out_type, ids[i], tys[i]);
         end
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      vectors++;
      if ({ul_count, dl_count, err_count, out_valid} !== {8'd2, 8'd2, 8'd0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL basic_counts: got ul=%0d dl=%0d err=%0d v=%b expected 2 2 0 0",
                  ul_count, dl_count, err_count, out_valid);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] ids [6];
      do_reset();
      for (int i = 0; i < 6; i++) begin
         ids[i] = 8'($urandom);
         step(1'b1, ids[i], 1'b0, 1'b0);
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL overflow_fill%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      vectors++;
      if (drop_count !== 8'd2) begin
         miscompares++;
         $display("[TB] FAIL overflow_drops: got %0d expected 2", drop_count);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({out_valid, out_id} !== {1'b1, ids[i]}) begin
            miscompares++;
            $display("[TB] FAIL overflow_drain%0d: got %b/%h expected 1/%h", i, out_valid, out_id, ids[i]);
         end
         step(1'b0, 8'h00, 1'b0, 1'b1);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL overflow_empty: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] ids [4];
      int pops;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ids[i] = 8'($urandom);
         step(1'b1, ids[i], 1'b1, 1'b0);
      end
      vectors++;
      if (out_id !== ids[0]) begin
         miscompares++;
         $display("[TB] FAIL fullpp_oldest: got %h expected %h", out_id, ids[0]);
      end
      step(1'b1, 8'h3C, 1'b0, 1'b1);
      vectors++;
      if ({drop_count, out_valid, out_id} !== {8'd0, 1'b1, ids[1]} || dut_vec !== exp_vec()) begin
         miscompares++;
         $display("[TB] FAIL fullpp_nodrop: got drop=%0d head=%h expected drop=0 head=%h",
                  drop_count, out_id, ids[1]);
      end
      pops = 0;
      for (int i = 0; i < 10 && out_valid === 1'b1; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1);
         pops++;
      end
      vectors++;
      if (pops != 4) begin
         miscompares++;
         $display("[TB] FAIL fullpp_occupancy: got %0d entries expected 4", pops);
      end
   endtask

   task automatic test_first_mismatch();
      do_reset();
      step(1'b1, 8'h00, 1'b0, 1'b1);
      vectors++;
      if ({err_count, err_seen} !== {8'd1, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL mismatch_first: got err=%0d seen=%b expected 1 1", err_count, err_seen);
      end
      step(1'b1, 8'h54, 1'b0, 1'b1);
      vectors++;
      if ({err_count, err_seen} !== {8'd1, 1'b1} || dut_vec !== exp_vec()) begin
         miscompares++;
         $display("[TB] FAIL mismatch_advance: got err=%0d seen=%b expected 1 1", err_count, err_seen);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 260; i++) begin
         step(1'b1, ~m_ul_exp, 1'b0, 1'($urandom));
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL saturate_cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      vectors++;
      if ({err_count, ul_count} !== {8'd255, 8'd4}) begin
         miscompares++;
         $display("[TB] FAIL saturate_final: got err=%0d ul=%0d expected 255 4", err_count, ul_count);
      end
   endtask

   task automatic test_random();
      logic       v, t;
      logic [7:0] id;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         t  = 1'($urandom);
         id = ($urandom_range(0, 3) != 0) ? (t ? m_dl_exp : m_ul_exp) : 8'($urandom);
         step(v, id, t, ($urandom_range(0, 2) != 0));
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL random_cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      step(1'b1, 8'h54, 1'b0, 1'b0);
      vectors++;
      if (dut_vec !== exp_vec() || err_seen !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL resetmid_setup: got %h expected %h", dut_vec, exp_vec());
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (dut_vec !== 43'd0) begin
         miscompares++;
         $display("[TB] FAIL resetmid_async: got %h expected %h", dut_vec, 43'd0);
      end
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      vectors++;
      if ({err_count, err_seen, out_valid, out_id} !== {8'd0, 1'b0, 1'b1, 8'hAA} || dut_vec !== exp_vec()) begin
         miscompares++;
         $display("[TB] FAIL resetmid_seed: got err=%0d seen=%b head=%h expected 0 0 aa",
                  err_count, err_seen, out_id);
      end
   endtask

   initial begin
      test_reset();
      test_basic_stream();
      test_overflow();
      test_full_push_pop();
      test_first_mismatch();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pkt_rx_checker.md
# pkt_rx_checker

Downstream consumer of the traffic generator's packet stream (`packet_id`, `packet_type`, `valid`). It buffers accepted packets in a small FIFO and presents them on a valid/ready output port. It counts received, dropped and erroneous packets. It checks every incoming ID against locally regenerated UL/DL LFSR sequences, so a bench or the chip top can confirm the generator end to end.

## Interface

- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `UL_SEED`, 8'hAA: expected UL LFSR seed.
- `UL_TAPS`, 8'hB4: expected UL LFSR taps.
- `DL_SEED`, 8'h55: expected DL LFSR seed.
- `DL_TAPS`, 8'hD8: expected DL LFSR taps.

- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: one-cycle packet strobe; no backpressure upstream.
- `in_id`, in, 8: packet ID.
- `in_type`, in, 1: 0 = UL, 1 = DL.
- `out_valid`, out, 1: FIFO head valid.
- `out_ready`, in, 1: consumer accepts head.
- `out_id`, out, 8: head packet ID.
- `out_type`, out, 1: head packet type.
- `ul_count`, out, 8: UL packets received; wraps.
- `dl_count`, out, 8: DL packets received; wraps.
- `drop_count`, out, 8: packets dropped on full FIFO; saturates at 255.
- `err_count`, out, 8: sequence mismatches; saturates at 255.
- `err_seen`, out, 1: sticky; set on first mismatch.

## Operation

- Reset values:
  - All outputs 0, FIFO empty.
  - Expected UL register = `UL_SEED`; expected DL register = `DL_SEED`.
- Push:
  - `in_valid` is accepted into the FIFO iff occupancy < `DEPTH`, or a pop occurs in the same cycle.
  - Otherwise the packet is dropped and `drop_count` increments (saturating).
- Pop: occurs when `out_valid && out_ready`.
- Full FIFO with simultaneous push and pop: both happen; occupancy is unchanged; nothing is dropped.
- Empty FIFO with simultaneous push: the new entry is not visible combinationally; it appears the next cycle.
- Per-type counters:
  - `ul_count`/`dl_count` increment on every `in_valid`, including dropped packets.
  - 8-bit, wrap 255 -> 0.
- Checker runs on every `in_valid`, including dropped packets:
  - Selects the expected register by `in_type` and compares it to `in_id`.
  - Mismatch: `err_count` increments (saturating); `err_seen` is set.
  - The selected register then advances regardless of match: `next = {cur[6:0], ^(cur & TAPS)}`.
  - The other type's register holds.
- Type alternation is not checked; only the per-type sequences are.

## Timing

- Input is sampled at edge k. If accepted, `out_valid` = 1 with that data after edge k (1-cycle latency) when the FIFO was empty.
- Output hold: while `out_valid && !out_ready`, `out_id`/`out_type` are stable.
- Output data comes from registered FIFO storage plus read pointer; no combinational path from `in_*` to `out_*`.
- `out_ready` may change any cycle, and may be high while `out_valid` = 0 (no effect).
- All counters and `err_seen` update at the edge that samples the triggering `in_valid`; they are visible the following cycle.
- Pointers are `$clog2(DEPTH)` bits with a separate occupancy count of `$clog2(DEPTH)+1` bits; pointers wrap modulo `DEPTH`.
- Reset asserted mid-operation:
  - FIFO contents are discarded.
  - All counters clear and the expected registers reload their seeds immediately (asynchronous).
  - The first packet after deassertion is checked against the seed.

## Structure

- Shared package `traffic_pkg`:
  - `PKT_UL` = 1'b0, `PKT_DL` = 1'b1.
  - Default seed/tap constants (8'hAA/8'hB4, 8'h55/8'hD8), shared with the generator.
  - 9-bit packet struct/typedef `{type, id}`.
- Sub-module `pkt_fifo`:
  - Parameterised width/depth synchronous FIFO with push/pop/full/empty/head.
  - Push gating, drop logic, counters and the checker live in `pkt_rx_checker`.
- The expected-LFSR next-state is a package function shared with the generator's LFSR equation.

## Test plan

- Reset, then UL IDs AA, 54 and DL IDs 55, AA with `out_ready` = 1:
  - Output stream AA/0, 55/1, 54/0, AA/1, each 1 cycle after its input.
  - `ul_count` = 2, `dl_count` = 2, `err_count` = 0.
- `out_ready` = 0, six packets sent:
  - First 4 buffered; `drop_count` = 2.
  - Raising `out_ready` drains exactly the first 4 in order.
- Full FIFO with push and pop in the same cycle: no drop; occupancy stays 4; popped head is the oldest entry.
- UL packet with ID 0x00 as first packet:
  - `err_count` = 1, `err_seen` = 1.
  - Next UL with ID 0x54 matches (register advanced).
- 260 forced-mismatch packets: `err_count` saturates at 255; `ul_count` wraps to 4.
- Reset pulsed with 3 entries buffered and `err_seen` = 1:
  - All outputs 0 asynchronously.
  - After release, a UL packet with ID AA gives no error.
